// File: rtl/gfg_spi_master_pkg.sv
// Shared definitions for the gfg SPI register link: opcodes, command byte layout
// and the master frame state encoding.
package gfg_spi_master_pkg;

    localparam logic [1:0] GFG_SPI_OP_WRITE = 2'b10;
    localparam logic [1:0] GFG_SPI_OP_READ  = 2'b01;
    localparam logic [1:0] GFG_SPI_OP_NOP   = 2'b00;

    localparam int CMD_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD,
        ST_FINISH
    } frame_state_t;

    // Command byte: op at [7:6], reserved zero at [5], address at [4:0].
    function automatic logic [7:0] cmd_byte(input logic [1:0] op,
                                            input logic [CMD_ADDR_W-1:0] addr);
        return {op, 1'b0, addr};
    endfunction

endpackage

// File: rtl/gfg_spi_master_bit_engine.sv
// Serialises one byte per start pulse: SCLK low half (MOSI valid), rising edge
// samples MISO, high half, eight times. Idles with SCLK high.
module gfg_spi_master_bit_engine #(
    parameter int CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] byte_in,
    input  logic       miso,
    output logic       byte_done,
    output logic [7:0] byte_out,
    output logic       sclk,
    output logic       mosi
);

    localparam int DW = $clog2(CLK_DIV);

    logic          active;
    logic          high_phase;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic          half_end;

    assign half_end = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 1'b0;
            high_phase <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx         <= '0;
            rx         <= '0;
        end else if (clear) begin
            active     <= 1'b0;
            high_phase <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
        end else if (start) begin
            active     <= 1'b1;
            high_phase <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx         <= byte_in;
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                if (!high_phase) begin
                    // SCLK rises on this edge; capture the slave's bit here.
                    high_phase <= 1'b1;
                    rx         <= {rx[6:0], miso};
                end else if (bit_cnt == 3'd7) begin
                    active     <= 1'b0;
                    high_phase <= 1'b0;
                end else begin
                    bit_cnt    <= bit_cnt + 3'd1;
                    high_phase <= 1'b0;
                    tx         <= {tx[6:0], 1'b0};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign byte_done = active & high_phase & half_end & (bit_cnt == 3'd7);
    assign byte_out  = rx;
    assign sclk      = ~(active & ~high_phase);
    assign mosi      = tx[7];

endmodule

// File: rtl/gfg_spi_master.sv
// SPI register-command master: frame FSM, byte sequencing, inter-byte gap and
// read-data assembly around the bit engine.
module gfg_spi_master
    import gfg_spi_master_pkg::*;
#(
    parameter int NUM_REGISTERS          = 32,
    parameter int REGISTER_WIDTH         = 32,
    parameter int CLK_DIV                = 5,
    parameter int GAP_CYCLES             = 10,
    parameter int DESELECT_BETWEEN_BYTES = 0,
    localparam int AW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
    input  logic                      i_sys_clk,
    input  logic                      i_arst_n,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [1:0]                i_cmd_op,
    input  logic [AW-1:0]             i_cmd_addr,
    input  logic [REGISTER_WIDTH-1:0] i_cmd_wdata,
    input  logic                      i_abort,
    output logic                      o_done,
    output logic                      o_aborted,
    output logic [REGISTER_WIDTH-1:0] o_rd_data,
    output logic                      o_spi_clk,
    output logic                      o_spi_mosi,
    input  logic                      i_spi_miso,
    output logic                      o_spi_ss_n
);

    localparam int NB      = REGISTER_WIDTH / 8;
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(NB + 2);

    frame_state_t              state, next;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             byte_idx;
    logic [BW-1:0]             last_idx;
    logic [1:0]                op_q;
    logic [CMD_ADDR_W-1:0]     addr_q;
    logic [REGISTER_WIDTH-1:0] wdata_q;
    logic [REGISTER_WIDTH-1:0] rd_shift;
    logic                      aborted_q;
    logic                      accept;
    logic                      start;
    logic                      clear;
    logic                      abort_go;
    logic                      byte_done;
    logic [7:0]                byte_in;
    logic [7:0]                byte_out;

    assign accept  = i_cmd_valid & (state == ST_IDLE);
    assign byte_in = (byte_idx == '0) ? cmd_byte(op_q, addr_q)
                                      : wdata_q[REGISTER_WIDTH-1 -: 8];

    always_comb begin
        next     = state;
        start    = 1'b0;
        clear    = 1'b0;
        abort_go = 1'b0;
        case (state)
            ST_IDLE:   if (accept) next = ST_SETUP;
            ST_SETUP:  if (cnt == CW'(CLK_DIV - 1)) begin
                           next  = ST_SHIFT;
                           start = 1'b1;
                       end
            ST_SHIFT:  if (byte_done) next = (byte_idx == last_idx) ? ST_HOLD : ST_GAP;
            ST_GAP:    if (cnt == CW'(GAP_CYCLES - 1)) begin
                           next  = ST_SHIFT;
                           start = 1'b1;
                       end
            ST_HOLD:   if (cnt == CW'(CLK_DIV - 1)) next = ST_FINISH;
            ST_FINISH: next = ST_IDLE;
            default:   next = ST_IDLE;
        endcase
        // Abort overrides every busy transition and parks the bit engine.
        if (i_abort && state != ST_IDLE && state != ST_FINISH) begin
            next     = ST_FINISH;
            start    = 1'b0;
            clear    = 1'b1;
            abort_go = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            byte_idx  <= '0;
            last_idx  <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_shift  <= '0;
            aborted_q <= 1'b0;
            o_rd_data <= '0;
        end else begin
            state <= next;
            if (next != state) begin
                cnt <= '0;
            end else if (state == ST_SETUP || state == ST_GAP || state == ST_HOLD) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                op_q      <= i_cmd_op;
                addr_q    <= CMD_ADDR_W'(i_cmd_addr);
                wdata_q   <= i_cmd_wdata;
                byte_idx  <= '0;
                last_idx  <= (i_cmd_op == GFG_SPI_OP_WRITE || i_cmd_op == GFG_SPI_OP_READ)
                             ? BW'(NB) : '0;
                aborted_q <= 1'b0;
            end
            if (abort_go) aborted_q <= 1'b1;
            if (byte_done && !abort_go) begin
                byte_idx <= byte_idx + 1'b1;
                // The command byte's MISO bits are never part of the read value.
                if (byte_idx != '0) begin
                    wdata_q  <= wdata_q << 8;
                    rd_shift <= (rd_shift << 8) | REGISTER_WIDTH'(byte_out);
                end
            end
            if (state == ST_HOLD && next == ST_FINISH && op_q == GFG_SPI_OP_READ) begin
                o_rd_data <= rd_shift;
            end
        end
    end

    gfg_spi_master_bit_engine #(
        .CLK_DIV(CLK_DIV)
    ) u_bit_engine (
        .clk      (i_sys_clk),
        .rst_n    (i_arst_n),
        .start    (start),
        .clear    (clear),
        .byte_in  (byte_in),
        .miso     (i_spi_miso),
        .byte_done(byte_done),
        .byte_out (byte_out),
        .sclk     (o_spi_clk),
        .mosi     (o_spi_mosi)
    );

    assign o_cmd_ready = (state == ST_IDLE);
    assign o_done      = (state == ST_FINISH);
    assign o_aborted   = (state == ST_FINISH) & aborted_q;
    assign o_spi_ss_n  = !(state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD ||
                           (state == ST_GAP && (DESELECT_BETWEEN_BYTES == 0 ||
                                                cnt == CW'(GAP_CYCLES - 1))));

endmodule

// File: tb/tb_gfg_spi_master.sv
// Bench for gfg_spi_master: two masters (contiguous and deselecting select) share
// one behavioural slave; a cycle-level timeline model checks every output.
module tb_gfg_spi_master;

    localparam int D    = 5;
    localparam int G    = 10;
    localparam int SLOT = 16 * D + G;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_addr = 5'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        abort = 1'b0;
    logic        miso = 1'b0;

    logic        ready0, done0, ab0, sclk0, mosi0, ssn0;
    logic        ready1, done1, ab1, sclk1, mosi1, ssn1;
    logic [31:0] rd0, rd1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    gfg_spi_master #(.NUM_REGISTERS(32), .REGISTER_WIDTH(32), .CLK_DIV(D),
                     .GAP_CYCLES(G), .DESELECT_BETWEEN_BYTES(0)) dut0 (
        .i_sys_clk(clk), .i_arst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(ready0),
        .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_abort(abort),
        .o_done(done0), .o_aborted(ab0), .o_rd_data(rd0), .o_spi_clk(sclk0),
        .o_spi_mosi(mosi0), .i_spi_miso(miso), .o_spi_ss_n(ssn0));

    gfg_spi_master #(.NUM_REGISTERS(32), .REGISTER_WIDTH(32), .CLK_DIV(D),
                     .GAP_CYCLES(G), .DESELECT_BETWEEN_BYTES(1)) dut1 (
        .i_sys_clk(clk), .i_arst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(ready1),
        .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_abort(abort),
        .o_done(done1), .o_aborted(ab1), .o_rd_data(rd1), .o_spi_clk(sclk1),
        .o_spi_mosi(mosi1), .i_spi_miso(miso), .o_spi_ss_n(ssn1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave, clocked by the first master's SCLK.
    bit   [31:0] regs [32];
    logic [7:0]  rx_q [$];
    int          frame_id = 0;
    int          s_fid = 0;
    int          s_bits = 0;
    logic [7:0]  s_sh = 8'd0;
    logic [7:0]  s_cmd = 8'd0;
    logic [31:0] s_data = 32'd0;
    logic [31:0] s_rval = 32'd0;

    always @(sclk0) begin
        if (s_fid != frame_id) begin
            s_fid  = frame_id;
            s_bits = 0;
            rx_q.delete();
        end
        if (sclk0 === 1'b1) begin
            if (ssn0 === 1'b0) begin
                s_sh = {s_sh[6:0], mosi0};
                if (s_bits >= 8) s_data = {s_data[30:0], mosi0};
                s_bits++;
                if (s_bits % 8 == 0) rx_q.push_back(s_sh);
                if (s_bits == 8) begin
                    s_cmd  = s_sh;
                    s_rval = regs[s_sh[4:0]];
                end
                if (s_bits == 40 && s_cmd[7:6] == 2'b10) regs[s_cmd[4:0]] = s_data;
            end
        end else begin
            if (s_bits >= 8 && s_bits < 40 && s_cmd[7:6] == 2'b01) miso = s_rval[31 - (s_bits - 8)];
            else miso = 1'b0;
        end
    end

    // Timeline model: every frame is fixed by accept cycle, byte count and abort.
    bit          busy = 0;
    bit          ab_f = 0;
    int          acc_c = 0, end_c = 0, nbytes = 0;
    logic [1:0]  m_op = 2'b00;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_rval = 32'd0;
    logic [31:0] exp_rd = 32'd0;
    int          last_acc = 0, last_end = 0;
    bit          last_ab = 0;

    always @(negedge clk) begin
        bit e_ready, e_done, e_sclk, e_ssn0, e_ssn1;
        int off, pos, r;
        logic [7:0] eb;
        if (!rst_n) begin
            busy   = 0;
            exp_rd = 32'd0;
            e_ready = 1; e_done = 0; e_sclk = 1; e_ssn0 = 1; e_ssn1 = 1;
            chk("reset_mosi0", mosi0, 1'b0);
            chk("reset_mosi1", mosi1, 1'b0);
        end else begin
            e_ready = !(busy && cyc <= end_c);
            e_done  = busy && cyc == end_c;
            e_sclk = 1; e_ssn0 = 1; e_ssn1 = 1;
            if (busy && cyc > acc_c && cyc < end_c) begin
                e_ssn0 = 0;
                e_ssn1 = 0;
                off = cyc - (acc_c + 1 + D);
                if (off >= 0) begin
                    pos = off / SLOT;
                    r   = off % SLOT;
                    if (pos < nbytes && r < 16 * D) e_sclk = ((r / D) % 2) == 1;
                    else if (pos < nbytes - 1 && r != SLOT - 1) e_ssn1 = 1;
                end
            end
            if (e_done) begin
                if (m_op == 2'b01 && !ab_f) exp_rd = m_rval;
                if (!ab_f) begin
                    chk("mosi_byte_count", rx_q.size(), nbytes);
                    chk("mosi_cmd_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, {m_op, 1'b0, m_addr});
                    if (m_op == 2'b10) begin
                        for (int k = 1; k < 5; k++) begin
                            eb = m_wdata[31 - 8 * (k - 1) -: 8];
                            chk("mosi_data_byte", (rx_q.size() > k) ? rx_q[k] : 8'hxx, eb);
                        end
                    end
                end
                last_acc = acc_c;
                last_end = end_c;
                last_ab  = ab_f;
            end
        end
        chk("ready0", ready0, e_ready);
        chk("ready1", ready1, e_ready);
        chk("done0", done0, e_done);
        chk("done1", done1, e_done);
        chk("aborted0", ab0, e_done && ab_f);
        chk("aborted1", ab1, e_done && ab_f);
        chk("sclk0", sclk0, e_sclk);
        chk("sclk1", sclk1, e_sclk);
        chk("ss_n0", ssn0, e_ssn0);
        chk("ss_n1", ssn1, e_ssn1);
        chk("rd_data0", rd0, exp_rd);
        chk("rd_data1", rd1, exp_rd);
        if (rst_n) begin
            if (busy && cyc > acc_c && cyc < end_c && abort) begin
                end_c = cyc + 1;
                ab_f  = 1;
            end
            if (e_ready && cmd_valid) begin
                busy    = 1;
                ab_f    = 0;
                acc_c   = cyc;
                m_op    = cmd_op;
                m_addr  = cmd_addr;
                m_wdata = cmd_wdata;
                m_rval  = regs[cmd_addr];
                nbytes  = (cmd_op == 2'b10 || cmd_op == 2'b01) ? 5 : 1;
                end_c   = cyc + (D + 16 * D * nbytes + G * (nbytes - 1) + D) + 1;
                frame_id++;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 1'b0, 1'b1);
        @(posedge clk);
    endtask

    initial begin
        logic [7:0] lit [5];
        int first_end;
        lit = '{8'h9F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready0, 1'b1);
        chk("rst_sclk", sclk0, 1'b1);
        chk("rst_ss_n", ssn0, 1'b1);
        chk("rst_done", done0, 1'b0);
        chk("rst_rd_data", rd0, 32'd0);
        rst_n = 1'b1;

        // Write 0xDEADBEEF to addr 31.
        issue(2'b10, 5'd31, 32'hDEADBEEF);
        wait_done();
        chk("write_done_latency", last_end - last_acc, 451);
        chk("write_slave_reg31", regs[31], 32'hDEADBEEF);
        for (int k = 0; k < 5; k++)
            chk("write_lit_byte", (rx_q.size() > k) ? rx_q[k] : 8'hxx, lit[k]);

        // Preload addr 0 then read it back through both masters.
        issue(2'b10, 5'd0, 32'h89ABCDEF);
        wait_done();
        issue(2'b01, 5'd0, 32'h0);
        wait_done();
        chk("read_rd_data0", rd0, 32'h89ABCDEF);
        chk("read_rd_data1", rd1, 32'h89ABCDEF);
        chk("read_not_aborted", last_ab, 1'b0);

        // Nop and invalid op: single command byte, 90-cycle select.
        issue(2'b00, 5'd31, 32'hFFFF_FFFF);
        wait_done();
        chk("nop_ss_low", last_end - last_acc - 1, 90);
        chk("nop_byte", (rx_q.size() == 1) ? rx_q[0] : 8'hxx, 8'h1F);
        issue(2'b11, 5'd31, 32'hFFFF_FFFF);
        wait_done();
        chk("inv_ss_low", last_end - last_acc - 1, 90);
        chk("inv_byte", (rx_q.size() == 1) ? rx_q[0] : 8'hxx, 8'hDF);
        chk("nop_reg31_kept", regs[31], 32'hDEADBEEF);
        chk("nop_reg0_kept", regs[0], 32'h89ABCDEF);

        // Abort during bit 13 of a write to addr 10.
        issue(2'b10, 5'd10, 32'hCAFEF00D);
        repeat (149) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done();
        chk("abort_flag", last_ab, 1'b1);
        chk("abort_done_cycle", last_end - last_acc, 151);
        chk("abort_no_write", regs[10], 32'd0);
        chk("abort_rd_kept", rd0, 32'h89ABCDEF);

        // Reset in the middle of the command byte, then a clean write.
        issue(2'b10, 5'd5, 32'h1111_2222);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sclk", sclk0, 1'b1);
        chk("midrst_ss_n", ssn0, 1'b1);
        chk("midrst_ready", ready0, 1'b1);
        chk("midrst_done", done0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(2'b10, 5'd31, 32'd37);
        wait_done();
        chk("postrst_reg31", regs[31], 32'd37);
        chk("postrst_reg5", regs[5], 32'd0);

        // Valid held across a frame while op/addr change.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 5'd7; cmd_wdata = 32'h0BADF00D;
        repeat (100) @(posedge clk);
        #1 cmd_op = 2'b01; cmd_addr = 5'd31;
        wait_done();
        first_end = last_end;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done();
        chk("b2b_reg7", regs[7], 32'h0BADF00D);
        chk("b2b_second_accept", last_acc, first_end + 1);
        chk("b2b_read", rd0, 32'd37);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
